imem_loader: RTL and testbench

- Boot-time program loader directly upstream of the single-cycle RISC-V core's instruction memory.
- Accepts a byte stream (length header, payload, checksum) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially into imem from word address 0.
- Holds the core in reset until a load completes with a correct checksum.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader-side bundle: byte stream in, imem write port and core control out.
interface imem_loader_if #(parameter int ADDR_W = 6);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata, core_reset, busy, done, err
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata, core_reset, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length header, LSB-first instruction words into imem, XOR checksum.
// Keeps the core in reset until a load finishes with a matching checksum.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  localparam logic [16:0] DEPTH_L = 17'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [7:0]        r_chk;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [23:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_core_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_acc;
  logic [15:0]       w_len;
  logic              w_last_word;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN0, S_LEN1, S_DATA, S_CHK: w_ready = 1'b1;
      default:                       w_ready = 1'b0;
    endcase
  end

  assign w_acc       = bus.in_valid && w_ready;
  assign w_len       = {bus.in_data, r_len[7:0]};
  // word_cnt still holds the index of the word being completed
  assign w_last_word = ({{(15 - ADDR_W){1'b0}}, r_word_cnt} + 16'd1) == r_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_chk        <= '0;
      r_byte_cnt   <= '0;
      r_word_cnt   <= '0;
      r_word       <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_state      <= S_LEN0;
            r_len        <= '0;
            r_chk        <= '0;
            r_byte_cnt   <= '0;
            r_word_cnt   <= '0;
            r_word       <= '0;
            r_waddr      <= '0;
            r_busy       <= 1'b1;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
          end
        end
        S_LEN0: begin
          if (w_acc) begin
            r_len[7:0] <= bus.in_data;
            r_chk      <= r_chk ^ bus.in_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_acc) begin
            r_len <= w_len;
            r_chk <= r_chk ^ bus.in_data;
            if ({1'b0, w_len} > DEPTH_L) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_len == 16'd0) begin
              r_state <= S_CHK;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_chk      <= r_chk ^ bus.in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= bus.in_data;
              2'd1: r_word[15:8]  <= bus.in_data;
              2'd2: r_word[23:16] <= bus.in_data;
              default: begin
                // Write data is captured whole here, so the next word's
                // byte 0 can land in r_word during the write cycle.
                r_we       <= 1'b1;
                r_wdata    <= {bus.in_data, r_word};
                r_waddr    <= r_word_cnt[ADDR_W-1:0];
                r_word_cnt <= r_word_cnt + 1'b1;
                if (w_last_word) r_state <= S_CHK;
              end
            endcase
          end
        end
        S_CHK: begin
          if (w_acc) begin
            r_busy <= 1'b0;
            if (bus.in_data == r_chk) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_reset = r_core_reset;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, captures imem writes, checks results.
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tot = 0;
  int n_pass = 0;
  logic [7:0]        stream[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wa_q.push_back(bus.imem_waddr);
      wd_q.push_back(bus.imem_wdata);
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    return x;
  endfunction

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 8 && !bus.in_ready; t++) @(negedge clk);
    if (!bus.in_ready) begin
      check("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_range(int lo, int hi, int gap);
    for (int i = lo; i < hi; i++) send_byte(stream[i], gap);
  endtask

  task automatic build_good();
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    stream.push_back(xsum());
  endtask

  task automatic check_writes(string tag, int n);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
      check({tag, "_data"}, wd_q[i], {stream[2+4*i+3], stream[2+4*i+2],
                                      stream[2+4*i+1], stream[2+4*i]});
    end
  endtask

  task automatic check_done(string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_coreRst"}, 32'(bus.core_reset), 32'd0);
  endtask

  task automatic check_err(string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_coreRst"}, 32'(bus.core_reset), 32'd1);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_coreRst"}, 32'(bus.core_reset), 32'd1);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Good two-word load, valid every cycle; checksum 02^13^05^10^93^05^20 = B2
    build_good();
    check("good_xsum", 32'(stream[10]), 32'h0000_00B2);
    clear_q();
    pulse_start();
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_ready", 32'(bus.in_ready), 32'd1);
    send_range(0, 6, 0);
    check("lat_we", 32'(bus.imem_we), 32'd1);
    check("lat_addr", 32'(bus.imem_waddr), 32'd0);
    check("lat_data", bus.imem_wdata, 32'h0010_0513);
    send_range(6, 10, 0);
    check("w1_data", bus.imem_wdata, 32'h0020_0593);
    check("w1_addr", 32'(bus.imem_waddr), 32'd1);
    check("pre_chk_coreRst", 32'(bus.core_reset), 32'd1);
    send_range(10, 11, 0);
    check_done("good");
    check_writes("good", 2);

    // Bad checksum: writes still happen, core stays in reset
    stream[10] = 8'h00;
    clear_q();
    pulse_start();
    check("restart_coreRst", 32'(bus.core_reset), 32'd1);
    check("restart_done", 32'(bus.done), 32'd0);
    send_range(0, 11, 0);
    check_err("badchk");
    check_writes("badchk", 2);

    // Oversize length 65 rejected right after the header
    stream = '{8'h41, 8'h00};
    clear_q();
    pulse_start();
    send_range(0, 2, 0);
    check_err("len65");
    @(negedge clk);
    check("len65_nwr", 32'(wa_q.size()), 32'd0);

    // Zero length: header then checksum 00
    stream = '{8'h00, 8'h00, 8'h00};
    clear_q();
    pulse_start();
    send_range(0, 3, 0);
    check_done("len0");
    check("len0_nwr", 32'(wa_q.size()), 32'd0);

    // Full depth: 64 words
    stream = '{8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      stream.push_back(8'(i + 3));
      stream.push_back(~8'(i));
      stream.push_back(8'(i) ^ 8'h5A);
      stream.push_back(8'(i));
    end
    stream.push_back(xsum());
    clear_q();
    pulse_start();
    send_range(0, stream.size(), 0);
    check_done("len64");
    check_writes("len64", 64);

    // Gaps of 3 idle cycles before every byte
    build_good();
    clear_q();
    pulse_start();
    send_range(0, 11, 3);
    check_done("gap");
    check_writes("gap", 2);

    // Reset during word 1, then a clean reload
    build_good();
    clear_q();
    pulse_start();
    send_range(0, 7, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    clear_q();
    pulse_start();
    send_range(0, 11, 0);
    check_done("postrst");
    check_writes("postrst", 2);

    // start while busy is ignored
    clear_q();
    pulse_start();
    send_range(0, 4, 0);
    pulse_start();
    check("busy_start_busy", 32'(bus.busy), 32'd1);
    check("busy_start_ready", 32'(bus.in_ready), 32'd1);
    send_range(4, 11, 0);
    check_done("busystart");
    check_writes("busystart", 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
